// File: rtl/uart_board_loader.sv
// uart_board_loader: parses a Life board typed over the UART RX byte stream
// (one character per cell, one line per row) into one-cell-per-cycle writes.
// Short rows are zero-filled, long rows are truncated, ESC cancels the load.
module uart_board_loader #(
  parameter int logWIDTH  = 3,
  parameter int logHEIGHT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic                          cell_we,
  output logic [logWIDTH+logHEIGHT-1:0] cell_addr,
  output logic                          cell_data,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic                          bad_char
);

  localparam int AW    = logWIDTH + logHEIGHT;
  localparam int WIDTH = 2 ** logWIDTH;
  localparam logic [logWIDTH:0] COL_LAST = (logWIDTH + 1)'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_PAD} state_e;

  state_e                 state_q, state_d;
  logic [logHEIGHT-1:0]   row_q, row_d;
  logic [logWIDTH:0]      col_q, col_d;   // one extra bit so it can hold WIDTH
  logic                   we_q, we_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   data_q, data_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic                   bad_q, bad_d;
  logic                   end_row;
  logic                   row_full;

  assign row_full = col_q[logWIDTH];

  // State and registered outputs; everything clears asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state: byte decode in RECV, zero-fill in PAD, shared end-of-row handling
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    we_d    = 1'b0;
    addr_d  = {row_q, col_q[logWIDTH-1:0]};
    data_d  = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    bad_d   = bad_q;
    end_row = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RECV;
          row_d   = '0;
          col_d   = '0;
          bad_d   = 1'b0;
        end
      end
      S_RECV: begin
        if (rx_valid) begin
          unique case (rx_data)
            8'h4F, 8'h2A, 8'h20, 8'h2E: begin
              if (!row_full) begin
                we_d   = 1'b1;
                data_d = (rx_data == 8'h4F) || (rx_data == 8'h2A);
                col_d  = col_q + 1'b1;
              end
            end
            8'h0D: ;
            8'h0A: begin
              if (row_full) begin
                end_row = 1'b1;
              end else begin
                // first pad write issues straight from the LF so it lands next cycle
                we_d  = 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == COL_LAST) end_row = 1'b1;
                else                   state_d = S_PAD;
              end
            end
            8'h1B: begin
              state_d = S_IDLE;
              abort_d = 1'b1;
            end
            default: bad_d = 1'b1;
          endcase
        end
      end
      S_PAD: begin
        we_d  = 1'b1;
        col_d = col_q + 1'b1;
        if (col_q == COL_LAST) end_row = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (end_row) begin
      col_d = '0;
      if (row_q == '1) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        row_d   = row_q + 1'b1;
        state_d = S_RECV;
      end
    end
  end

  assign rx_ready  = (state_q == S_RECV);
  assign busy      = (state_q != S_IDLE);
  assign cell_we   = we_q;
  assign cell_addr = addr_q;
  assign cell_data = data_q;
  assign done      = done_q;
  assign aborted   = abort_q;
  assign bad_char  = bad_q;

endmodule

// File: tb/tb_uart_board_loader.sv
// Bench for uart_board_loader: text streams are turned into an expected list of
// cell writes by a line-oriented reference model and compared with the DUT.
module tb_uart_board_loader;
  localparam int W = 8, H = 8;

  logic       clk = 1'b0, reset, start, rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready, cell_we, cell_data, busy, done, aborted, bad_char;
  logic [5:0] cell_addr;

  uart_board_loader #(.logWIDTH(3), .logHEIGHT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cell_we(cell_we), .cell_addr(cell_addr), .cell_data(cell_data),
    .busy(busy), .done(done), .aborted(aborted), .bad_char(bad_char));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] stim[$];
  int exp_addr[$], exp_data[$];
  bit exp_done, exp_abort, exp_bad;
  int got_addr[$], got_data[$], got_cyc[$], got_rdy[$];
  int done_cnt, abort_cnt, done_busy;
  logic [7:0] cc[4] = '{8'h4F, 8'h2A, 8'h20, 8'h2E};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cell_we) begin
      got_addr.push_back(int'(cell_addr)); got_data.push_back(int'(cell_data));
      got_cyc.push_back(cyc); got_rdy.push_back(int'(rx_ready));
    end
    if (done) begin done_cnt++; done_busy = int'(busy); end
    if (aborted) abort_cnt++;
  end

  // Reference: each cell char lands at row*W + (cells so far on this line);
  // LF zero-fills the rest of the line; the load ends after H lines or at ESC.
  function automatic void model();
    int r = 0, c = 0;
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_abort = 0; exp_bad = 0;
    for (int i = 0; i < stim.size(); i++) begin
      if (exp_done || exp_abort) break;
      case (stim[i])
        8'h4F, 8'h2A, 8'h20, 8'h2E: if (c < W) begin
          exp_addr.push_back(r * W + c);
          exp_data.push_back((stim[i] == 8'h4F || stim[i] == 8'h2A) ? 1 : 0);
          c++;
        end
        8'h0D: ;
        8'h0A: begin
          for (int k = c; k < W; k++) begin exp_addr.push_back(r * W + k); exp_data.push_back(0); end
          c = 0; r++;
          if (r == H) exp_done = 1;
        end
        8'h1B: exp_abort = 1;
        default: exp_bad = 1;
      endcase
    end
  endfunction

  task automatic add_row(input string s, input bit cr);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    if (cr) stim.push_back(8'h0D);
    stim.push_back(8'h0A);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      errors++; $display("FAIL send_timeout byte=%02h rx_ready never rose", b);
    end else @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic run_load(input bit inject);
    int n = 0;
    got_addr.delete(); got_data.delete(); got_cyc.delete(); got_rdy.delete();
    done_cnt = 0; abort_cnt = 0; done_busy = -1;
    model();
    pulse_start();
    for (int i = 0; i < stim.size(); i++) begin
      if (inject && i == stim.size() / 2) pulse_start();
      send_byte(stim[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    while (busy && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin errors++; $display("FAIL idle_timeout busy=%0d want 0", busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #3;
    checks++;
    if ({rx_ready, cell_we, cell_addr, cell_data, busy, done, aborted, bad_char} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0",
        {rx_ready, cell_we, cell_addr, cell_data, busy, done, aborted, bad_char});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b rx_ready=%b want 0 0", busy, rx_ready);
    end
  endtask

  task automatic test_full_rows();
    stim.delete();
    add_row("OOOOOOOO", 0);
    for (int r = 1; r < H; r++) add_row("........", 1);
    run_load(0);
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL full_count got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin errors++; $display("FAIL full_write[%0d] got %0d/%0d want %0d/%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    checks++; if (done_cnt !== 1 || done_busy !== 0) begin errors++; $display("FAIL full_done cnt=%0d busy=%0d want 1 0", done_cnt, done_busy); end
    checks++; if (bad_char !== 1'b0 || abort_cnt !== 0) begin errors++; $display("FAIL full_flags bad=%b abort=%0d want 0 0", bad_char, abort_cnt); end
  endtask

  task automatic test_pad();
    stim.delete();
    add_row("O", 0);
    for (int r = 1; r < H; r++) add_row("*. O  *.", 0);
    run_load(1);
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL pad_count got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin errors++; $display("FAIL pad_write[%0d] got %0d/%0d want %0d/%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    if (got_addr.size() >= 8) begin
      for (int k = 2; k < 8; k++) begin
        checks++;
        if (got_cyc[k] !== got_cyc[1] + k - 1) begin errors++; $display("FAIL pad_consecutive[%0d] cycle %0d want %0d", k, got_cyc[k], got_cyc[1] + k - 1); end
      end
      for (int k = 1; k < 7; k++) begin
        checks++;
        if (got_rdy[k] !== 0) begin errors++; $display("FAIL pad_rx_ready[%0d] got %0d want 0", k, got_rdy[k]); end
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pad_done cnt=%0d want 1", done_cnt); end
  endtask

  task automatic test_overflow();
    stim.delete();
    add_row("OOOOOOOOOO", 0);
    for (int r = 1; r < H; r++) add_row(" .......", 1);
    run_load(0);
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin errors++; $display("FAIL ovf_write[%0d] got %0d/%0d want %0d/%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ovf_done cnt=%0d want 1", done_cnt); end
  endtask

  task automatic test_esc();
    stim.delete();
    for (int r = 0; r < 3; r++) add_row("O.O.O.O.", 0);
    stim.push_back(8'h1B);
    run_load(0);
    checks++; if (got_addr.size() !== 24 || exp_addr.size() !== 24) begin errors++; $display("FAIL esc_count got %0d want 24", got_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin errors++; $display("FAIL esc_write[%0d] got %0d/%0d want %0d/%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    checks++; if (abort_cnt !== 1 || done_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL esc_flags abort=%0d done=%0d busy=%b want 1 0 0", abort_cnt, done_cnt, busy); end
  endtask

  task automatic test_bad_char();
    stim.delete();
    stim.push_back(8'h4F); stim.push_back(8'h4F); stim.push_back(8'h78);
    add_row("OOOOOO", 0);
    for (int r = 1; r < H; r++) add_row("........", 0);
    run_load(0);
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL bad_count got %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin errors++; $display("FAIL bad_write[%0d] got %0d/%0d want %0d/%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    checks++; if (bad_char !== exp_bad) begin errors++; $display("FAIL bad_sticky got %b want %b", bad_char, exp_bad); end
    pulse_start();
    checks++; if (bad_char !== 1'b0) begin errors++; $display("FAIL bad_clear got %b want 0", bad_char); end
    send_byte(8'h1B);
    @(negedge clk);
  endtask

  task automatic test_reset_in_pad();
    pulse_start();
    send_byte(8'h4F);
    send_byte(8'h0A);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rx_ready, cell_we, cell_addr, cell_data, busy, done, aborted, bad_char} !== 13'd0) begin
      errors++; $display("FAIL pad_reset_outputs got %b want 0",
        {rx_ready, cell_we, cell_addr, cell_data, busy, done, aborted, bad_char});
    end
    @(negedge clk); reset = 1'b0; @(negedge clk);
    stim.delete();
    for (int r = 0; r < H; r++) add_row("O O O O ", 1);
    run_load(0);
    checks++; if (got_addr.size() !== exp_addr.size() || (got_addr.size() > 0 && got_addr[0] !== 0)) begin errors++; $display("FAIL after_reset_first count %0d want %0d", got_addr.size(), exp_addr.size()); end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin errors++; $display("FAIL after_reset_write[%0d] got %0d/%0d want %0d/%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL after_reset_done cnt=%0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      stim.delete();
      for (int r = 0; r < H; r++) begin
        int n = $urandom_range(0, 10);
        for (int k = 0; k < n; k++) begin
          int p = $urandom_range(0, 19);
          if (p == 0) stim.push_back(8'h78);
          else if (p == 1) stim.push_back(8'h0D);
          else stim.push_back(cc[p % 4]);
        end
        if ($urandom_range(0, 1) == 1) stim.push_back(8'h0D);
        stim.push_back(8'h0A);
      end
      if ($urandom_range(0, 3) == 0) begin
        int cut = $urandom_range(0, stim.size() - 1);
        while (stim.size() > cut) void'(stim.pop_back());
        stim.push_back(8'h1B);
      end
      run_load($urandom_range(0, 1));
      checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, got_addr.size(), exp_addr.size()); end
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin errors++; $display("FAIL rnd%0d_write[%0d] got %0d/%0d want %0d/%0d", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]); end
      end
      checks++;
      if (done_cnt !== int'(exp_done) || abort_cnt !== int'(exp_abort) || bad_char !== exp_bad) begin
        errors++; $display("FAIL rnd%0d_flags done=%0d abort=%0d bad=%b want %0d %0d %b", it, done_cnt, abort_cnt, bad_char, exp_done, exp_abort, exp_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_rows();
    test_pad();
    test_overflow();
    test_esc();
    test_bad_char();
    test_reset_in_pad();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
